fc_neuron_array: RTL and testbench
==================================

# fc_neuron_array

Parametrised, multi-neuron fully-connected engine: `N_NEURONS` neurons share one serial input stream, and each neuron has its own writable weight/bias memory. The block accepts `PREV_HEIGHT` input words over a valid/ready handshake, multiply-accumulates them in parallel across all neurons, adds the per-neuron bias, and rounds and saturates each result. It then presents all neuron outputs as one wide word over a valid/ready handshake. It replaces single-neuron instances plus external sequencing in FC layers; the internal sequencer, backpressure and saturation are new.

## Interface
- `WORD_SIZE`, 16, signed fixed-point word width (inputs, weights, bias, outputs)
- `N_SIZE`, 8, fractional bits of every word
- `PREV_HEIGHT`, 4, input words per frame (≥1)
- `N_NEURONS`, 4, parallel neurons (≥1)
- `RAM_ADDRESS_BITS`, `$clog2(PREV_HEIGHT+1)`, weight memory address width
- `NEURON_SEL_BITS`, `N_NEURONS>1 ? $clog2(N_NEURONS) : 1`, neuron-select width
- Clocking and reset (already decided): one clock, `clk_i`; reset `reset_n_i` is asynchronous and active-low.
- `clk_i` in 1 clock
- `reset_n_i` in 1 asynchronous active-low reset
- `valid_i` in 1 input word valid
- `ready_o` out 1 block can accept an input word
- `data_i` in WORD_SIZE signed input word
- `valid_o` out 1 result frame valid
- `ready_i` in 1 downstream accepts result
- `data_o` out N_NEURONS*WORD_SIZE results; neuron n occupies `[n*WORD_SIZE +: WORD_SIZE]`
- `w_en_i` in 1 weight write strobe
- `w_neuron_i` in NEURON_SEL_BITS target neuron
- `w_addr_i` in RAM_ADDRESS_BITS addresses 0..PREV_HEIGHT-1 hold weights; address PREV_HEIGHT holds the bias
- `w_data_i` in WORD_SIZE write data
- `idle_o` out 1 high when no frame is in progress (weight writes allowed)

## Operation
- FSM states:
  - ACC: `ready_o=1`. Each accepted beat (`valid_i & ready_o`) registers `data_i` and `W[n][cnt]` for all n, then `cnt++`. Accepting beat `cnt==PREV_HEIGHT-1` moves the FSM to BIAS.
  - BIAS: accumulate the last product and register the bias word. Next cycle: add the bias, shift, saturate, load `data_o`, set `valid_o`, move to DONE.
  - DONE: hold `data_o`/`valid_o` until `ready_i`. On the handshake: clear the accumulators and `cnt`, deassert `valid_o`, return to ACC.
- `ready_o` is low in BIAS and DONE. Frames never overlap.
- `idle_o = (state==ACC) & (cnt==0) & no product in flight`.
- Arithmetic:
  - Product: full 2*WORD_SIZE signed width.
  - Accumulator: 2*WORD_SIZE + RAM_ADDRESS_BITS signed; it never overflows.
  - Bias: sign-extended, shifted left by N_SIZE, then added.
  - Result: arithmetic shift right by N_SIZE (truncates toward −inf), then saturate to [−2^(WORD_SIZE−1), 2^(WORD_SIZE−1)−1].
- Weight writes happen only when `w_en_i & idle_o`. Otherwise the write is silently dropped. Out-of-range `w_neuron_i`/`w_addr_i` is dropped.
- Weight memory is not reset.
- Reset (any time, including mid-frame):
  - Forced values: state ACC, `cnt=0`, accumulators 0, `valid_o=0`, `data_o=0`, `ready_o=1`, `idle_o=1`.
  - A partial frame is discarded.

## Timing
- Weight memory read: registered, one cycle (address = `cnt` at the accept edge).
- Last beat accepted at edge E0:
  - E1: last product accumulated; bias registered.
  - E2: `valid_o=1` with final `data_o`.
  - Latency from last accept to `valid_o`: 2 cycles.
- Output handshake completes at edge Ek. `ready_o` is high after Ek, so the earliest next accept is Ek+1.
- Full-throughput input is one word per cycle in ACC; bubbles (`valid_i=0`) are allowed anywhere.
- `data_o` is stable while `valid_o & !ready_i`.

## Configuration
- `FC_RELU_EN` defined: ReLU is applied after saturation; negative results output as 0.
- `FC_RELU_EN` undefined: signed saturated result passes through unchanged.

## Test plan
All scenarios use WORD_SIZE=16, N_SIZE=8, PREV_HEIGHT=4, N_NEURONS=2, with ReLU disabled unless stated.
- Basic frame:
  - Setup: neuron 0 weights 0x0100×4, bias 0x0080; neuron 1 weights 0xFF00×4, bias 0.
  - Stimulus: inputs 0x0100, 0x0200, 0x0300, 0x0400 back-to-back.
  - Response: `data_o` = {0xF600, 0x0A80}, `valid_o` 2 cycles after last accept.
- ReLU: same stimulus with `FC_RELU_EN` defined -> neuron 1 = 0x0000, neuron 0 = 0x0A80.
- Saturation:
  - Weights 0x7FFF with inputs 0x7FFF -> 0x7FFF.
  - Weights 0x8000 with inputs 0x7FFF -> 0x8000.
- Backpressure and bubbles:
  - Stimulus: insert `valid_i` gaps between inputs; hold `ready_i=0` for 5 cycles after `valid_o`.
  - Response: identical results; `data_o` stable; `ready_o=0` throughout; extra `valid_i` beats not consumed.
- Write gating: `w_en_i` while `idle_o=0` (mid-frame) -> weight unchanged; the next frame's result uses the old weight.
- Reset mid-frame:
  - Stimulus: assert `reset_n_i=0` after 2 beats; then run a full basic frame.
  - Response: immediately after reset, `valid_o=0`, `data_o=0`, `ready_o=1`; the subsequent basic frame yields {0xF600, 0x0A80}.

Source files
------------

// File: rtl/fc_neuron_array.sv
// Multi-neuron fully-connected engine: serial input MAC across N_NEURONS, bias add, round/saturate.
// Optional build macro FC_RELU_EN clamps negative results to zero after saturation.
module fc_neuron_array #(
  parameter int unsigned WORD_SIZE        = 16,
  parameter int unsigned N_SIZE           = 8,
  parameter int unsigned PREV_HEIGHT      = 4,
  parameter int unsigned N_NEURONS        = 4,
  parameter int unsigned RAM_ADDRESS_BITS = $clog2(PREV_HEIGHT + 1),
  parameter int unsigned NEURON_SEL_BITS  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic signed [WORD_SIZE-1:0]       data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [N_NEURONS*WORD_SIZE-1:0]    data_o,
  input  logic                              w_en_i,
  input  logic [NEURON_SEL_BITS-1:0]        w_neuron_i,
  input  logic [RAM_ADDRESS_BITS-1:0]       w_addr_i,
  input  logic [WORD_SIZE-1:0]              w_data_i,
  output logic                              idle_o
);

  localparam int unsigned PROD_W = 2 * WORD_SIZE;
  localparam int unsigned ACC_W  = 2 * WORD_SIZE + RAM_ADDRESS_BITS;
  localparam int unsigned DEPTH  = PREV_HEIGHT + 1;
  localparam logic [RAM_ADDRESS_BITS-1:0] LAST_ADDR  = RAM_ADDRESS_BITS'(PREV_HEIGHT - 1);
  localparam logic [RAM_ADDRESS_BITS-1:0] BIAS_ADDR  = RAM_ADDRESS_BITS'(PREV_HEIGHT);
  localparam logic [NEURON_SEL_BITS:0]    NEURON_LIM = (NEURON_SEL_BITS + 1)'(N_NEURONS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {S_ACC, S_BIAS, S_DONE} state_t;

  state_t                             r_state, w_state_nxt;
  logic [RAM_ADDRESS_BITS-1:0]        r_cnt, w_cnt_nxt;
  logic                               r_prod_vld, w_prod_vld_nxt;
  logic                               r_bias_vld, w_bias_vld_nxt;
  logic signed [WORD_SIZE-1:0]        r_x, w_x_nxt;
  logic signed [WORD_SIZE-1:0]        r_w [N_NEURONS];
  logic signed [WORD_SIZE-1:0]        w_w_nxt [N_NEURONS];
  logic signed [WORD_SIZE-1:0]        r_b [N_NEURONS];
  logic signed [WORD_SIZE-1:0]        w_b_nxt [N_NEURONS];
  logic signed [ACC_W-1:0]            r_acc [N_NEURONS];
  logic signed [ACC_W-1:0]            w_acc_nxt [N_NEURONS];
  logic [N_NEURONS*WORD_SIZE-1:0]     r_data, w_data_nxt;
  logic                               r_valid, w_valid_nxt;
  logic                               r_ready, w_ready_nxt;
  logic                               r_idle, w_idle_nxt;
  logic signed [WORD_SIZE-1:0]        r_mem [N_NEURONS][DEPTH];

  logic                               w_accept;
  logic                               w_wr_ok;
  logic signed [PROD_W-1:0]           w_prod [N_NEURONS];
  logic signed [ACC_W-1:0]            w_sum  [N_NEURONS];
  logic signed [ACC_W-1:0]            w_shf  [N_NEURONS];
  logic signed [WORD_SIZE-1:0]        w_res  [N_NEURONS];

  assign w_accept = valid_i & r_ready;
  assign w_wr_ok  = w_en_i & r_idle & ({1'b0, w_neuron_i} < NEURON_LIM) & (w_addr_i <= BIAS_ADDR);

  assign ready_o = r_ready;
  assign idle_o  = r_idle;
  assign valid_o = r_valid;
  assign data_o  = r_data;

  // Weight/bias memory: writable only between frames, never reset
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) begin
      r_mem[w_neuron_i][w_addr_i] <= w_data_i;
    end
  end

  // Products, bias alignment, floor shift, saturation
  always_comb begin
    for (int n = 0; n < N_NEURONS; n++) begin
      w_prod[n] = r_x * r_w[n];
      w_sum[n]  = r_acc[n] + (ACC_W'(r_b[n]) <<< N_SIZE);
      w_shf[n]  = w_sum[n] >>> N_SIZE;
      if (w_shf[n] > SAT_MAX) begin
        w_res[n] = SAT_MAX[WORD_SIZE-1:0];
      end else if (w_shf[n] < SAT_MIN) begin
        w_res[n] = SAT_MIN[WORD_SIZE-1:0];
      end else begin
        w_res[n] = w_shf[n][WORD_SIZE-1:0];
      end
`ifdef FC_RELU_EN
      if (w_res[n][WORD_SIZE-1]) begin
        w_res[n] = '0;
      end
`endif
    end
  end

  // Sequencer next state and datapath next values
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_prod_vld_nxt = 1'b0;
    w_bias_vld_nxt = r_bias_vld;
    w_x_nxt        = r_x;
    w_w_nxt        = r_w;
    w_b_nxt        = r_b;
    w_acc_nxt      = r_acc;
    w_data_nxt     = r_data;
    w_valid_nxt    = r_valid;

    if (r_prod_vld) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        w_acc_nxt[n] = r_acc[n] + ACC_W'(w_prod[n]);
      end
    end

    case (r_state)
      S_ACC: begin
        if (w_accept) begin
          w_x_nxt        = data_i;
          w_prod_vld_nxt = 1'b1;
          w_cnt_nxt      = r_cnt + RAM_ADDRESS_BITS'(1);
          for (int n = 0; n < N_NEURONS; n++) begin
            w_w_nxt[n] = r_mem[n][r_cnt];
          end
          if (r_cnt == LAST_ADDR) begin
            w_state_nxt = S_BIAS;
          end
        end
      end
      S_BIAS: begin
        if (!r_bias_vld) begin
          w_bias_vld_nxt = 1'b1;
          for (int n = 0; n < N_NEURONS; n++) begin
            w_b_nxt[n] = r_mem[n][BIAS_ADDR];
          end
        end else begin
          w_bias_vld_nxt = 1'b0;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = S_DONE;
          for (int n = 0; n < N_NEURONS; n++) begin
            w_data_nxt[n*WORD_SIZE +: WORD_SIZE] = w_res[n];
          end
        end
      end
      S_DONE: begin
        if (ready_i) begin
          w_state_nxt = S_ACC;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          for (int n = 0; n < N_NEURONS; n++) begin
            w_acc_nxt[n] = '0;
          end
        end
      end
      default: w_state_nxt = S_ACC;
    endcase

    w_ready_nxt = (w_state_nxt == S_ACC);
    w_idle_nxt  = w_ready_nxt & (w_cnt_nxt == '0) & !w_prod_vld_nxt;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_ACC;
      r_cnt      <= '0;
      r_prod_vld <= 1'b0;
      r_bias_vld <= 1'b0;
      r_x        <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b1;
      r_idle     <= 1'b1;
      for (int n = 0; n < N_NEURONS; n++) begin
        r_w[n]   <= '0;
        r_b[n]   <= '0;
        r_acc[n] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_prod_vld <= w_prod_vld_nxt;
      r_bias_vld <= w_bias_vld_nxt;
      r_x        <= w_x_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_ready    <= w_ready_nxt;
      r_idle     <= w_idle_nxt;
      for (int n = 0; n < N_NEURONS; n++) begin
        r_w[n]   <= w_w_nxt[n];
        r_b[n]   <= w_b_nxt[n];
        r_acc[n] <= w_acc_nxt[n];
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron_array.sv
// Directed + randomized bench for fc_neuron_array (2 neurons, 4 inputs, Q8.8), arithmetic reference model.
module tb_fc_neuron_array;

  localparam int NN = 2;
  localparam int PH = 4;

`ifdef FC_RELU_EN
  localparam logic [31:0] EXP_BASIC = 32'h0000_0A80;
  localparam logic [31:0] EXP_SAT   = 32'h0000_7FFF;
`else
  localparam logic [31:0] EXP_BASIC = 32'hF600_0A80;
  localparam logic [31:0] EXP_SAT   = 32'h8000_7FFF;
`endif

  logic               clk_i = 1'b0;
  logic               reset_n_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [15:0] data_i;
  logic               valid_o;
  logic               ready_i;
  logic [31:0]        data_o;
  logic               w_en_i;
  logic [0:0]         w_neuron_i;
  logic [2:0]         w_addr_i;
  logic [15:0]        w_data_i;
  logic               idle_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] mdl_w [NN][PH+1];

  fc_neuron_array #(
    .WORD_SIZE(16), .N_SIZE(8), .PREV_HEIGHT(PH), .N_NEURONS(NN)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .w_en_i(w_en_i), .w_neuron_i(w_neuron_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum of products plus scaled bias, floor-divide by 2^8, clamp
  function automatic logic [31:0] model(input logic signed [15:0] xs [PH]);
    logic [31:0] r;
    longint s, q;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      s = longint'(mdl_w[n][PH]) * 256;
      for (int i = 0; i < PH; i++) s += longint'(xs[i]) * longint'(mdl_w[n][i]);
      q = s / 256;
      if ((s % 256 != 0) && (s < 0)) q -= 1;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
`ifdef FC_RELU_EN
      if (q < 0) q = 0;
`endif
      r[n*16 +: 16] = 16'(q);
    end
    return r;
  endfunction

  task automatic wr(input int n, input int a, input logic [15:0] d, input bit takes);
    @(negedge clk_i);
    w_en_i = 1'b1; w_neuron_i = 1'(n); w_addr_i = 3'(a); w_data_i = d;
    @(negedge clk_i);
    w_en_i = 1'b0;
    if (takes) mdl_w[n][a] = d;
  endtask

  task automatic load_neuron(input int n, input logic [15:0] w, input logic [15:0] b);
    for (int a = 0; a < PH; a++) wr(n, a, w, 1'b1);
    wr(n, PH, b, 1'b1);
  endtask

  task automatic run_frame(input logic signed [15:0] xs [PH], input logic [31:0] exp,
                           input int max_gap, input int hold, input bit mid_wr, input string tag);
    int g;
    for (int i = 0; i < PH; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk_i); valid_i = 1'b0; data_i = 16'($urandom);
      end
      if (mid_wr && i == 2) begin
        @(negedge clk_i);
        valid_i = 1'b0;
        chk({tag, " idle_mid"}, 32'(idle_o), 32'd0);
        w_en_i = 1'b1; w_neuron_i = 1'b0; w_addr_i = 3'd2; w_data_i = 16'h0500;
      end
      @(negedge clk_i);
      w_en_i = 1'b0; valid_i = 1'b1; data_i = xs[i];
      chk({tag, " ready_acc"}, 32'(ready_o), 32'd1);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b1; data_i = 16'($urandom);
    chk({tag, " valid_e0"}, 32'(valid_o), 32'd0);
    chk({tag, " ready_e0"}, 32'(ready_o), 32'd0);
    @(negedge clk_i);
    chk({tag, " valid_e1"}, 32'(valid_o), 32'd0);
    chk({tag, " ready_e1"}, 32'(ready_o), 32'd0);
    @(negedge clk_i);
    chk({tag, " valid_e2"}, 32'(valid_o), 32'd1);
    chk({tag, " data"}, data_o, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk({tag, " hold_valid"}, 32'(valid_o), 32'd1);
      chk({tag, " hold_data"}, data_o, exp);
      chk({tag, " hold_ready"}, 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0; valid_i = 1'b0;
    chk({tag, " valid_after"}, 32'(valid_o), 32'd0);
    chk({tag, " ready_after"}, 32'(ready_o), 32'd1);
    chk({tag, " idle_after"}, 32'(idle_o), 32'd1);
  endtask

  initial begin
    logic signed [15:0] xb [PH];
    logic signed [15:0] xs [PH];
    logic [15:0] wv;
    int v;

    xb = '{16'sh0100, 16'sh0200, 16'sh0300, 16'sh0400};
    reset_n_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    w_en_i = 1'b0; w_neuron_i = '0; w_addr_i = '0; w_data_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst data_o", data_o, 32'd0);
    chk("rst ready_o", 32'(ready_o), 32'd1);
    chk("rst idle_o", 32'(idle_o), 32'd1);
    reset_n_i = 1'b1;

    load_neuron(0, 16'h0100, 16'h0080);
    load_neuron(1, 16'hFF00, 16'h0000);
    chk("model basic", model(xb), EXP_BASIC);
    run_frame(xb, EXP_BASIC, 0, 0, 1'b0, "basic");
    run_frame(xb, EXP_BASIC, 2, 5, 1'b0, "bp");

    // Mid-frame write must be dropped, now and in the following frame
    run_frame(xb, EXP_BASIC, 0, 1, 1'b1, "wgate");
    run_frame(xb, EXP_BASIC, 0, 0, 1'b0, "wgate_next");
    wr(0, 7, 16'h1234, 1'b0);
    run_frame(xb, EXP_BASIC, 1, 0, 1'b0, "oob_addr");

    load_neuron(0, 16'h7FFF, 16'h0000);
    load_neuron(1, 16'h8000, 16'h0000);
    xs = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
    run_frame(xs, EXP_SAT, 0, 2, 1'b0, "sat");

    for (int it = 0; it < 6; it++) begin
      for (int n = 0; n < NN; n++) begin
        for (int a = 0; a <= PH; a++) begin
          v = int'($urandom_range(1023, 0)) - 512;
          wv = (it % 2 == 0) ? 16'($urandom) : 16'(v);
          wr(n, a, wv, 1'b1);
        end
      end
      for (int i = 0; i < PH; i++) begin
        v = int'($urandom_range(2047, 0)) - 1024;
        xs[i] = (it % 3 == 0) ? 16'($urandom) : 16'(v);
      end
      run_frame(xs, model(xs), 2, int'($urandom_range(3, 0)), 1'b0, "rand");
    end

    // Reset after two accepted beats discards the partial frame
    load_neuron(0, 16'h0100, 16'h0080);
    load_neuron(1, 16'hFF00, 16'h0000);
    run_frame(xb, EXP_BASIC, 0, 0, 1'b0, "pre_rst");
    @(negedge clk_i); valid_i = 1'b1; data_i = xb[0];
    @(negedge clk_i); data_i = xb[1];
    @(negedge clk_i); valid_i = 1'b0;
    chk("midrst idle_before", 32'(idle_o), 32'd0);
    reset_n_i = 1'b0;
    #1;
    chk("midrst valid_o", 32'(valid_o), 32'd0);
    chk("midrst data_o", data_o, 32'd0);
    chk("midrst ready_o", 32'(ready_o), 32'd1);
    chk("midrst idle_o", 32'(idle_o), 32'd1);
    @(negedge clk_i); reset_n_i = 1'b1;
    run_frame(xb, EXP_BASIC, 0, 0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
